// File: rtl/gs_window3x3.sv
// 3x3 neighbourhood generator for a raster grayscale stream: two line RAMs plus a
// 3x3 shift register; emits one window per interior pixel, one cycle after acceptance.
module gs_window3x3 #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int PIX_W = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [PIX_W-1:0]           gs,
    input  logic                       gs_valid,
    input  logic                       sof,
    output logic [9*PIX_W-1:0]         win,
    output logic                       win_valid,
    output logic [$clog2(IMG_W)-1:0]   win_x,
    output logic [$clog2(IMG_H)-1:0]   win_y,
    output logic                       frame_done
);
    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

    logic [XW-1:0] col, col_eff;
    logic [YW-1:0] row, row_eff;
    logic [PIX_W-1:0] lb0 [IMG_W];
    logic [PIX_W-1:0] lb1 [IMG_W];
    logic [PIX_W-1:0] rd0, rd1;
    logic [8:0][PIX_W-1:0] w;

    // sof re-anchors the current pixel to (0,0) whatever the counters say
    always_comb begin
        col_eff = sof ? '0 : col;
        row_eff = sof ? '0 : row;
    end

    assign rd0 = lb0[col_eff];
    assign rd1 = lb1[col_eff];

    // Reads above see the pre-write contents, so lb1 cascades into lb0 correctly
    always_ff @(posedge clk) begin
        if (gs_valid) begin
            lb1[col_eff] <= gs;
            lb0[col_eff] <= rd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (gs_valid) begin
            if (col_eff == X_LAST) begin
                col <= '0;
                row <= (row_eff == Y_LAST) ? '0 : row_eff + 1'b1;
            end else begin
                col <= col_eff + 1'b1;
                row <= row_eff;
            end
        end
    end

    // Element 3*r+c; new column enters at c=2, top row comes from the oldest line
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w <= '0;
        end else if (gs_valid) begin
            for (int r = 0; r < 3; r++) begin
                w[3*r]   <= w[3*r+1];
                w[3*r+1] <= w[3*r+2];
            end
            w[2] <= rd0;
            w[5] <= rd1;
            w[8] <= gs;
        end
    end

    assign win = w;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
            win_x      <= '0;
            win_y      <= '0;
        end else begin
            win_valid  <= gs_valid && (col_eff >= XW'(2)) && (row_eff >= YW'(2));
            frame_done <= gs_valid && !sof && (col == X_LAST) && (row == Y_LAST);
            if (gs_valid) begin
                win_x <= col_eff - 1'b1;
                win_y <= row_eff - 1'b1;
            end
        end
    end
endmodule
